// File: rtl/systolic_sequencer.sv
// systolic_sequencer: operand buffers, skewed feed and result streaming for an output-stationary systolic array
module systolic_sequencer #(
  parameter int NUM_ROW = 8,
  parameter int NUM_COL = 4,
  parameter int K_MAX   = 8,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [3:0]                         k_len,
  input  logic                               wr_en,
  input  logic                               wr_sel,
  input  logic [5:0]                         wr_addr,
  input  logic [DATA_W-1:0]                  wr_data,
  output logic [NUM_ROW*DATA_W-1:0]          left_inputs,
  output logic [NUM_COL*DATA_W-1:0]          top_inputs,
  output logic                               mac_clear,
  input  logic [NUM_ROW*NUM_COL*ACC_W-1:0]   pe_results,
  output logic [7:0]                         out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy,
  output logic                               done,
  output logic [5:0]                         cycle_count
);
  localparam int RW = NUM_ROW * NUM_COL * ACC_W;
  localparam int NB = RW / 8;
  localparam int IW = $clog2(NB);
  localparam int KW = $clog2(K_MAX);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, CAPTURE, STREAM} state_t;
  state_t                    r_state;
  logic [DATA_W-1:0]         r_a [NUM_ROW][K_MAX];
  logic [DATA_W-1:0]         r_b [K_MAX][NUM_COL];
  logic [RW-1:0]             r_res;
  logic [NUM_ROW*DATA_W-1:0] r_left;
  logic [NUM_COL*DATA_W-1:0] r_top;
  logic [NUM_ROW*DATA_W-1:0] w_left;
  logic [NUM_COL*DATA_W-1:0] w_top;
  logic [5:0]                r_cnt;
  logic [3:0]                r_k;
  logic [IW-1:0]             r_idx;
  logic [7:0]                r_od;
  logic                      r_ov;
  logic                      r_clr;
  logic                      r_done;
  logic                      r_drn;
  logic [3:0]                w_kc;
  logic [5:0]                w_tl;
  logic [IW-1:0]             w_ni;
  assign w_kc = k_len > 4'(K_MAX) ? 4'(K_MAX) : k_len;
  assign w_tl = 6'(r_k) + 6'(NUM_ROW + NUM_COL - 3);
  assign w_ni = r_idx + IW'(1);
  // Row r sees A[r][t-r]: the skew lines operands up so PE(r,c) meets k = t-r-c from both sides
  for (genvar r = 0; r < NUM_ROW; r++) begin : g_l
    logic [5:0] w_d;
    assign w_d = r_cnt - 6'(r);
    assign w_left[r*DATA_W +: DATA_W] = (r_cnt >= 6'(r) && w_d < 6'(r_k)) ? r_a[r][w_d[KW-1:0]] : '0;
  end
  for (genvar c = 0; c < NUM_COL; c++) begin : g_t
    logic [5:0] w_d;
    assign w_d = r_cnt - 6'(c);
    assign w_top[c*DATA_W +: DATA_W] = (r_cnt >= 6'(c) && w_d < 6'(r_k)) ? r_b[w_d[KW-1:0]][c] : '0;
  end
  // Operand writes only while idle; result snapshot in CAPTURE; these buffers are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en && r_state == IDLE && !wr_sel) r_a[wr_addr[5:3]][wr_addr[2:0]] <= wr_data;
    if (wr_en && r_state == IDLE && wr_sel && !wr_addr[2]) r_b[wr_addr[5:3]][wr_addr[1:0]] <= wr_data;
    if (r_state == CAPTURE) r_res <= pe_results;
  end
  // Sequencer FSM with registered bus, clear, stream and completion outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_left  <= '0;
      r_top   <= '0;
      r_clr   <= 1'b0;
      r_done  <= 1'b0;
      r_ov    <= 1'b0;
      r_od    <= '0;
      r_cnt   <= '0;
      r_k     <= '0;
      r_idx   <= '0;
      r_drn   <= 1'b0;
    end else begin
      r_left <= r_state == FEED ? w_left : '0;
      r_top  <= r_state == FEED ? w_top : '0;
      r_clr  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state <= CLEAR;
          r_clr   <= 1'b1;
          r_cnt   <= '0;
          r_k     <= w_kc;
        end
        CLEAR: r_state <= r_k == 4'd0 ? CAPTURE : FEED;
        FEED: begin
          r_drn <= 1'b0;
          if (r_cnt == w_tl) r_state <= DRAIN;
          else r_cnt <= r_cnt + 6'd1;
        end
        DRAIN: begin
          r_drn <= 1'b1;
          if (r_drn) r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_state <= STREAM;
          r_ov    <= 1'b1;
          r_od    <= pe_results[7:0];
          r_idx   <= '0;
        end
        STREAM: if (out_ready) begin
          if (r_idx == IW'(NB - 1)) begin
            r_state <= IDLE;
            r_ov    <= 1'b0;
            r_od    <= '0;
            r_done  <= 1'b1;
          end else begin
            r_idx <= w_ni;
            r_od  <= r_res[{w_ni, 3'b000} +: 8];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign left_inputs = r_left;
  assign top_inputs  = r_top;
  assign mac_clear   = r_clr;
  assign out_data    = r_od;
  assign out_valid   = r_ov;
  assign busy        = r_state != IDLE;
  assign done        = r_done;
  assign cycle_count = r_cnt;
endmodule

// File: tb/tb_systolic_sequencer.sv
// tb_systolic_sequencer: directed vectors against a behavioural 8x4 PE array and a matrix-product reference
module tb_systolic_sequencer;
  logic         clk = 0;
  logic         rst_n = 0;
  logic         start = 0;
  logic [3:0]   k_len = 0;
  logic         wr_en = 0;
  logic         wr_sel = 0;
  logic [5:0]   wr_addr = 0;
  logic [7:0]   wr_data = 0;
  logic [63:0]  left_inputs;
  logic [31:0]  top_inputs;
  logic         mac_clear;
  logic [511:0] pe_results;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1;
  logic         busy;
  logic         done;
  logic [5:0]   cycle_count;

  systolic_sequencer dut (
    .clk(clk), .rst(rst_n), .start(start), .k_len(k_len),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .left_inputs(left_inputs), .top_inputs(top_inputs), .mac_clear(mac_clear),
    .pe_results(pe_results), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // behavioural output-stationary array: operands shift right/down, each PE accumulates its inputs
  logic [7:0]  ar [8][4];
  logic [7:0]  br [8][4];
  logic [15:0] acc [8][4];

  function automatic logic [7:0] ain(int r, int c);
    return c == 0 ? left_inputs[8*r +: 8] : ar[r][c == 0 ? 0 : c - 1];
  endfunction
  function automatic logic [7:0] bin(int r, int c);
    return r == 0 ? top_inputs[8*c +: 8] : br[r == 0 ? 0 : r - 1][c];
  endfunction

  always @(posedge clk)
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++) begin
        ar[r][c]  <= ain(r, c);
        br[r][c]  <= bin(r, c);
        acc[r][c] <= mac_clear ? 16'd0 : acc[r][c] + 16'(ain(r, c)) * 16'(bin(r, c));
      end

  always_comb begin
    pe_results = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++)
        pe_results[16*(r*4+c) +: 16] = acc[r][c];
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] ma [8][8];
  logic [7:0] mb [8][4];
  logic [7:0] got [64];
  int ngot;

  typedef struct {
    int k; int pat; bit tog; bit inj; int cnt; int lat;
    logic [7:0] lo; logic [7:0] hi; logic [7:0] b0;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic sel, input logic [5:0] addr, input logic [7:0] data);
    wr_en = 1; wr_sel = sel; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic load(input int pat);
    logic [7:0] v;
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) begin
        v = pat == 0 ? 8'd1 : pat == 1 ? 8'(r + 1) : 8'hFF;
        ma[r][k] = v;
        wr(0, 6'(r*8 + k), v);
      end
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < 4; c++) begin
        v = pat == 0 ? 8'd1 : pat == 1 ? 8'(c + 1) : 8'hFF;
        mb[k][c] = v;
        wr(1, 6'(k*8 + c), v);
        wr(1, 6'(k*8 + 4 + c), 8'hEE);
      end
  endtask

  function automatic logic [15:0] ref_pe(int r, int c, int kk);
    logic [15:0] s = 0;
    for (int k = 0; k < kk; k++) s += 16'(ma[r][k]) * 16'(mb[k][c]);
    return s;
  endfunction

  task automatic run_op(input int k, input bit tog, input bit inj, output int lat, output int ndone,
                        output bit bus_nz, output int bad, output bit ok);
    int cyc = 0, c0 = -1, post = -1;
    bit pv = 0, pr = 0;
    logic [7:0] pd = 0;
    lat = -1; ndone = 0; bus_nz = 0; bad = 0; ngot = 0;
    start = 1; k_len = 4'(k);
    @(negedge clk);
    start = 0;
    while (cyc < 400 && (post < 0 || cyc < post + 3)) begin
      out_ready = tog ? (cyc % 2 == 0) : 1'b1;
      if (inj && cyc == 4) begin
        start = 1; k_len = 5; wr_en = 1; wr_sel = 0; wr_addr = 0; wr_data = 8'h55;
      end
      if (inj && cyc == 5) begin
        start = 0; wr_en = 0;
      end
      if (mac_clear && c0 < 0) c0 = cyc;
      if (out_valid && lat < 0) lat = cyc - c0;
      if (|left_inputs || |top_inputs) bus_nz = 1;
      if (pv && !pr && (!out_valid || out_data !== pd)) bad++;
      if (out_valid && out_ready) begin
        if (ngot < 64) got[ngot] = out_data;
        ngot++;
      end
      if (done) begin
        ndone++;
        if (post < 0) post = cyc;
      end
      pv = out_valid; pr = out_ready; pd = out_data;
      @(negedge clk);
      cyc++;
    end
    ok = post >= 0;
    out_ready = 1;
  endtask

  initial begin
    int lat, ndone, bad, mism, kk, n;
    bit bus_nz, ok;
    logic [15:0] e;
    tbl[0] = '{8,  0, 0, 0, 17, 22, 8'h08, 8'h00, 8'h08};
    tbl[1] = '{3,  1, 0, 0, 12, 17, 8'h60, 8'h00, 8'h03};
    tbl[2] = '{12, 0, 0, 0, 17, 22, 8'h08, 8'h00, 8'h08};
    tbl[3] = '{0,  1, 0, 0, 0,  2,  8'h00, 8'h00, 8'h00};
    tbl[4] = '{8,  2, 1, 0, 17, 22, 8'h08, 8'hF0, 8'h08};
    tbl[5] = '{1,  1, 1, 0, 10, 15, 8'h20, 8'h00, 8'h01};
    tbl[6] = '{3,  1, 0, 1, 12, 17, 8'h60, 8'h00, 8'h03};

    repeat (3) @(negedge clk);
    chk("rst_left", left_inputs, 0);
    chk("rst_top", top_inputs, 0);
    chk("rst_ctl", {mac_clear, out_valid, busy, done}, 0);
    chk("rst_data", out_data, 0);
    chk("rst_cnt", cycle_count, 0);
    rst_n = 1;
    @(negedge clk);

    load(1);
    start = 1; k_len = 3;
    @(negedge clk);
    start = 0;
    chk("clear_cycle", {mac_clear, busy}, 2'b11);
    @(negedge clk);
    chk("feed0_left", left_inputs, 0);
    chk("feed0_cnt", cycle_count, 0);
    @(negedge clk);
    chk("feed1_left", left_inputs, 64'h1);
    chk("feed1_top", top_inputs, 32'h1);
    chk("feed1_cnt", cycle_count, 1);
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("seq_done", done, 1);
    @(negedge clk);

    start = 1; k_len = 3;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    chk("pre_rst_left", left_inputs != 0, 1);
    rst_n = 0;
    #1;
    chk("async_bus", {left_inputs, top_inputs} != 0, 0);
    chk("async_ctl", {mac_clear, out_valid, busy, done}, 0);
    chk("async_cnt", cycle_count, 0);
    @(negedge clk);
    rst_n = 1;
    ndone = 0; n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) n++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_idle", n, 0);

    for (int i = 0; i < 7; i++) begin
      load(tbl[i].pat);
      run_op(tbl[i].k, tbl[i].tog, tbl[i].inj, lat, ndone, bus_nz, bad, ok);
      chk($sformatf("v%0d_timeout", i), ok, 1);
      chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("v%0d_cycle_count", i), cycle_count, tbl[i].cnt);
      chk($sformatf("v%0d_done_pulses", i), ndone, 1);
      chk($sformatf("v%0d_bytes", i), ngot, 64);
      chk($sformatf("v%0d_stall_hold", i), bad, 0);
      chk($sformatf("v%0d_bus_active", i), bus_nz, tbl[i].k != 0);
      chk($sformatf("v%0d_pe73", i), {got[63], got[62]}, {tbl[i].hi, tbl[i].lo});
      chk($sformatf("v%0d_pe00_lo", i), got[0], tbl[i].b0);
      kk = tbl[i].k > 8 ? 8 : tbl[i].k;
      mism = 0;
      for (int j = 0; j < 64; j++) begin
        e = ref_pe((j / 2) / 4, (j / 2) % 4, kk);
        if (got[j] !== ((j % 2) ? e[15:8] : e[7:0])) mism++;
      end
      chk($sformatf("v%0d_stream", i), mism, 0);
      chk($sformatf("v%0d_idle", i), {busy, out_valid}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_sequencer.md
SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

Interface
REQ-001 SHALL provide parameters (name, default, meaning): NUM_ROW, 8, array rows; NUM_COL, 4, array columns; K_MAX, 8, maximum inner dimension; DATA_W, 8, operand width; ACC_W, 16, PE accumulator width.
REQ-002 SHALL provide ports (name, direction, width, meaning): clk, in, 1, sole clock; all logic on rising edge.
REQ-003 rst, in, 1, reset, asynchronous and active-low.
REQ-004 start, in, 1, single-cycle request to run one matrix product.
REQ-005 k_len, in, 4, inner dimension K, sampled on accepted start.
REQ-006 wr_en / wr_sel / wr_addr / wr_data, in, 1/1/6/8, operand write port: wr_sel 0 = A buffer, 1 = B buffer.
REQ-007 left_inputs, out, 64, registered activation bus, byte r drives array row r.
REQ-008 top_inputs, out, 32, registered weight bus, byte c drives array column c.
REQ-009 mac_clear, out, 1, active-high accumulator clear to all PEs.
REQ-010 pe_results, in, 512, PE accumulators, PE (r,c) at bits [16*(r*4+c) +: 16].
REQ-011 out_data / out_valid / out_ready, out/out/in, 8/1/1, result byte stream to UART transmitter.
REQ-012 busy, out, 1, high in every state except IDLE; done, out, 1, one-cycle completion pulse; cycle_count, out, 6, FEED-cycle counter.

Function
REQ-013 A write: row = wr_addr[5:3], k = wr_addr[2:0]; B write: k = wr_addr[5:3], col = wr_addr[1:0]; B writes with wr_addr[2]=1 SHALL be ignored.
REQ-014 Writes SHALL be accepted only in IDLE; wr_en while busy is ignored, buffer unchanged.
REQ-015 FSM states: IDLE, CLEAR, FEED, DRAIN, CAPTURE, STREAM.
REQ-016 IDLE -> CLEAR on start; start while busy SHALL be ignored.
REQ-017 k_len latched as K; K > 8 SHALL clamp to 8; K = 0 SHALL go CLEAR -> CAPTURE, skipping FEED/DRAIN.
REQ-018 CLEAR lasts exactly 1 cycle with mac_clear=1; mac_clear=0 in all other states.
REQ-019 FEED lasts T = K + NUM_ROW + NUM_COL - 2 cycles; cycle_count counts 0..T-1, holds final value until next CLEAR, zeroed in CLEAR.
REQ-020 At FEED cycle t: left byte r = A[r][t-r] when 0 <= t-r < K, else 0; top byte c = B[t-c][c] when 0 <= t-c < K, else 0.
REQ-021 Buses registered: value for cycle t visible on outputs in the cycle after t is computed; both buses 0 outside FEED.
REQ-022 DRAIN lasts exactly 2 cycles with buses 0; then CAPTURE.
REQ-023 CAPTURE lasts 1 cycle and registers all 512 pe_results bits into a result buffer.
REQ-024 STREAM sends 64 bytes: PE order row-major (r*4+c), low byte then high byte.
REQ-025 out_valid/out_ready handshake: byte transfers when both high; out_data and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 After 64th transfer: STREAM -> IDLE, done=1 for exactly that one cycle, out_valid=0.
REQ-027 Product per PE: sum over k of A[r][k]*B[k][c], unsigned, mod 2^16 (array arithmetic); sequencer does no arithmetic on results.

Reset
REQ-028 rst=0 SHALL immediately force IDLE, left_inputs=0, top_inputs=0, mac_clear=0, out_valid=0, out_data=0, busy=0, done=0, cycle_count=0, latched K=0.
REQ-029 Operand and result buffers SHALL NOT be reset; contents undefined after power-up until written.
REQ-030 Reset in any state mid-operation SHALL abort it with no done pulse; after release, first start SHALL run normally.

Verification
REQ-031 A all 1, B all 1, K=8, out_ready=1 -> T=18 FEED cycles, 64 bytes alternating 0x08,0x00, done pulses once.
REQ-032 A[r][k]=r+1, B[k][c]=c+1, K=3 -> first FEED output left=0x...01 (row 0 only) top=0x00000001; PE(7,3) bytes 0x60,0x00.
REQ-033 K=0 -> CLEAR, CAPTURE, STREAM; zero FEED cycles, cycle_count=0, bus outputs stay 0.
REQ-034 out_ready toggled 1/0 each cycle during STREAM -> each byte held while stalled, exactly 64 transfers, no duplicate or skipped byte.
REQ-035 start and wr_en asserted during FEED -> ignored, results equal undisturbed run; rst=0 pulse in FEED -> all outputs 0 same cycle, no done.
REQ-036 k_len=12 -> behaves exactly as K=8 (T=18, identical stream).
